// File: rtl/calc_pkg.sv
// Constants shared by the calculator top, the stack and the execution unit:
// command codes, stack pointer moves, capacity and the execution FSM encoding.
package calc_pkg;

    localparam int MAX_ELEM_CNT = 512;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_MUL = 3'd2;
    localparam logic [2:0] CMD_DIV = 3'd3;
    localparam logic [2:0] CMD_MOD = 3'd4;
    localparam logic [2:0] CMD_POP = 3'd5;
    localparam logic [2:0] CMD_DUP = 3'd6;
    localparam logic [2:0] CMD_SWP = 3'd7;

    localparam logic [1:0] ST_NO_MOV = 2'd0;
    localparam logic [1:0] ST_MOV_UP = 2'd1;
    localparam logic [1:0] ST_MOV_DN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIVIDE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT1  = 3'd3,
        S_WAIT2  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // POP and DUP only need one element on the stack; everything else needs two.
    function automatic logic needs_two(input logic [2:0] c);
        return !(c == CMD_POP || c == CMD_DUP);
    endfunction

endpackage

// File: rtl/div_u32.sv
// Restoring radix-2 unsigned divider. The first iteration happens on the start
// edge, so quotient/remainder are final in the cycle done is high, WIDTH cycles later.
module div_u32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    cnt_reg;
    logic             done_reg;

    // One shift-subtract step: the quotient register doubles as the dividend shifter.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] trial;
        trial = {r, q[WIDTH-1]};
        if (trial >= {1'b0, d}) begin
            trial = trial - {1'b0, d};
            return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        end
        return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                {rem_reg, quo_reg} <= div_step('0, dividend, divisor);
                dvs_reg            <= divisor;
                cnt_reg            <= CW'(WIDTH - 1);
            end else if (cnt_reg != '0) begin
                {rem_reg, quo_reg} <= div_step(rem_reg, quo_reg, dvs_reg);
                cnt_reg            <= cnt_reg - CW'(1);
                done_reg           <= (cnt_reg == CW'(1));
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;
    assign done      = done_reg;

endmodule

// File: rtl/stack_exec.sv
// Calculator command execution unit: validates a command against the stack
// state, computes the result and issues one write transaction to the stack.
module stack_exec
    import calc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = MAX_ELEM_CNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic [9:0]       elems_cnt,
    input  logic [WIDTH-1:0] top0,
    input  logic [WIDTH-1:0] top1,
    input  logic             st_ready,
    output logic             st_en,
    output logic [1:0]       st_write_elems_cnt,
    output logic [WIDTH-1:0] st_write_elem0,
    output logic [WIDTH-1:0] st_write_elem1,
    output logic [1:0]       st_top_mov,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t           state_reg;
    logic [2:0]       cmd_reg;
    logic             reject;
    logic             is_div;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [1:0]       wr_cnt;
    logic [1:0]       wr_mov;
    logic [WIDTH-1:0] wr_elem0;
    logic [WIDTH-1:0] wr_elem1;

    assign is_div = (cmd == CMD_DIV) || (cmd == CMD_MOD);

    always_comb begin
        reject = needs_two(cmd) ? (elems_cnt < 10'd2) : (elems_cnt == 10'd0);
        if (cmd == CMD_DUP && int'(elems_cnt) >= DEPTH) reject = 1'b1;
        if (is_div && top0 == '0) reject = 1'b1;
    end

    // Non-divide commands are resolved on the accept edge so st_en lands one cycle later.
    always_comb begin
        wr_cnt   = 2'd1;
        wr_mov   = ST_MOV_DN;
        wr_elem0 = '0;
        wr_elem1 = '0;
        case (cmd)
            CMD_ADD: wr_elem0 = top1 + top0;
            CMD_SUB: wr_elem0 = top1 - top0;
            CMD_MUL: wr_elem0 = top1 * top0;
            CMD_POP: wr_cnt   = 2'd0;
            CMD_DUP: begin
                wr_mov   = ST_MOV_UP;
                wr_elem0 = top0;
            end
            CMD_SWP: begin
                wr_cnt   = 2'd2;
                wr_mov   = ST_NO_MOV;
                wr_elem0 = top1;
                wr_elem1 = top0;
            end
            default: ;
        endcase
    end

    assign div_start = (state_reg == S_IDLE) && start && !reject && is_div;

    div_u32 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (top1),
        .divisor   (top0),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= S_IDLE;
            cmd_reg            <= CMD_ADD;
            st_en              <= 1'b0;
            st_write_elems_cnt <= 2'd0;
            st_write_elem0     <= '0;
            st_write_elem1     <= '0;
            st_top_mov         <= ST_NO_MOV;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        cmd_reg <= cmd;
                        if (reject) begin
                            state_reg <= S_DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else if (is_div) begin
                            state_reg <= S_DIVIDE;
                        end else begin
                            state_reg          <= S_ISSUE;
                            st_en              <= 1'b1;
                            st_write_elems_cnt <= wr_cnt;
                            st_write_elem0     <= wr_elem0;
                            st_write_elem1     <= wr_elem1;
                            st_top_mov         <= wr_mov;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        state_reg          <= S_ISSUE;
                        st_en              <= 1'b1;
                        st_write_elems_cnt <= 2'd1;
                        st_write_elem0     <= (cmd_reg == CMD_MOD) ? remainder : quotient;
                        st_write_elem1     <= '0;
                        st_top_mov         <= ST_MOV_DN;
                    end
                end
                S_ISSUE: begin
                    st_en     <= 1'b0;
                    state_reg <= S_WAIT1;
                end
                S_WAIT1: state_reg <= S_WAIT2;
                S_WAIT2: begin
                    if (st_ready) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_exec.sv
// Directed bench for stack_exec: each command is issued against a small stack
// ready model and checked for result fields, strobe/done cycles and errors.
module tb_stack_exec;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start;
    logic [2:0]  cmd;
    logic [9:0]  elems_cnt;
    logic [31:0] top0;
    logic [31:0] top1;
    logic        st_ready;
    logic        st_en;
    logic [1:0]  st_write_elems_cnt;
    logic [31:0] st_write_elem0;
    logic [31:0] st_write_elem1;
    logic [1:0]  st_top_mov;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    // Stack ready model: ready drops for the one cycle after each transaction strobe.
    logic st_busy_q = 1'b0;
    always @(posedge clk) st_busy_q <= st_en;
    assign st_ready = !st_busy_q;

    always #5 clk = ~clk;

    stack_exec #(.WIDTH(32), .DEPTH(512)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .cmd                (cmd),
        .elems_cnt          (elems_cnt),
        .top0               (top0),
        .top1               (top1),
        .st_ready           (st_ready),
        .st_en              (st_en),
        .st_write_elems_cnt (st_write_elems_cnt),
        .st_write_elem0     (st_write_elem0),
        .st_write_elem1     (st_write_elem1),
        .st_top_mov         (st_top_mov),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command in the current cycle (cycle 0) and follow it to done.
    task automatic run_cmd(input string tag, input logic [2:0] c, input logic [9:0] n,
                           input logic [31:0] t1, input logic [31:0] t0,
                           input logic exp_err, input int exp_st, input int exp_done,
                           input logic [1:0] exp_mov, input logic [1:0] exp_cnt,
                           input logic [31:0] exp_e0, input logic [31:0] exp_e1,
                           input logic extra_start);
        int st_cyc, done_cyc, st_n, done_n, busy_after;
        logic err_seen, busy_bad;
        logic [1:0] mov_s, cnt_s;
        logic [31:0] e0_s, e1_s;
        st_cyc = -1; done_cyc = -1; st_n = 0; done_n = 0; busy_after = -1;
        err_seen = 1'b0; busy_bad = 1'b0;
        mov_s = '0; cnt_s = '0; e0_s = '0; e1_s = '0;
        check({tag, "_idle_busy"}, 64'(busy), 64'(0));
        cmd = c; elems_cnt = n; top1 = t1; top0 = t0; start = 1'b1;
        tick();
        start = 1'b0; top1 = ~t1; top0 = ~t0; elems_cnt = 10'd0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (st_en) begin
                st_n++;
                if (st_cyc < 0) begin
                    st_cyc = cyc; mov_s = st_top_mov; cnt_s = st_write_elems_cnt;
                    e0_s = st_write_elem0; e1_s = st_write_elem1;
                end
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; err_seen = err;
                end
            end
            if (done_cyc < 0 && !busy) busy_bad = 1'b1;
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (extra_start && cyc == 2) begin
                start = 1'b1; cmd = CMD_ADD; elems_cnt = 10'd2;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_st_cycle"}, 64'(st_cyc), 64'(exp_st));
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_err"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_done_count"}, 64'(done_n), 64'(1));
        check({tag, "_st_count"}, 64'(st_n), 64'((exp_st >= 0) ? 1 : 0));
        check({tag, "_busy_during"}, 64'(busy_bad), 64'(0));
        check({tag, "_busy_after"}, 64'(busy_after), 64'(0));
        if (exp_st >= 0) begin
            check({tag, "_mov"}, 64'(mov_s), 64'(exp_mov));
            check({tag, "_cnt"}, 64'(cnt_s), 64'(exp_cnt));
            if (exp_cnt != 2'd0) check({tag, "_elem0"}, 64'(e0_s), 64'(exp_e0));
            if (exp_cnt == 2'd2) check({tag, "_elem1"}, 64'(e1_s), 64'(exp_e1));
        end
        $display("[TB] %s cmd=%0d cnt=%0d st_en@%0d done@%0d err=%0b elem0=%0h",
                 tag, c, n, st_cyc, done_cyc, err_seen, e0_s);
    endtask

    initial begin
        int stray;
        start = 1'b0; cmd = 3'd0; elems_cnt = 10'd0; top0 = '0; top1 = '0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_ctrl", {60'd0, busy, done, err, st_en}, 64'd0);
        check("reset_fields", {60'd0, st_write_elems_cnt, st_top_mov}, 64'd0);
        check("reset_elems", {st_write_elem0, st_write_elem1}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        run_cmd("add", CMD_ADD, 10'd2, 32'd7, 32'd5, 1'b0, 1, 4, ST_MOV_DN, 2'd1, 32'd12, 32'd0, 1'b0);
        run_cmd("sub_wrap", CMD_SUB, 10'd2, 32'd3, 32'd5, 1'b0, 1, 4, ST_MOV_DN, 2'd1, 32'hFFFF_FFFE, 32'd0, 1'b0);
        run_cmd("mul_ovf", CMD_MUL, 10'd3, 32'h1_0000, 32'h1_0000, 1'b0, 1, 4, ST_MOV_DN, 2'd1, 32'd0, 32'd0, 1'b0);
        run_cmd("mul", CMD_MUL, 10'd2, 32'h1_2345, 32'h10, 1'b0, 1, 4, ST_MOV_DN, 2'd1, 32'h12_3450, 32'd0, 1'b0);
        run_cmd("div", CMD_DIV, 10'd2, 32'd100, 32'd7, 1'b0, 33, 36, ST_MOV_DN, 2'd1, 32'd14, 32'd0, 1'b0);
        run_cmd("div_max", CMD_DIV, 10'd9, 32'hFFFF_FFFF, 32'd3, 1'b0, 33, 36, ST_MOV_DN, 2'd1, 32'h5555_5555, 32'd0, 1'b0);
        run_cmd("mod_max", CMD_MOD, 10'd2, 32'hFFFF_FFFF, 32'h10, 1'b0, 33, 36, ST_MOV_DN, 2'd1, 32'hF, 32'd0, 1'b0);
        run_cmd("mod", CMD_MOD, 10'd2, 32'd100, 32'd7, 1'b0, 33, 36, ST_MOV_DN, 2'd1, 32'd2, 32'd0, 1'b0);
        run_cmd("div_zero", CMD_DIV, 10'd2, 32'd100, 32'd0, 1'b1, -1, 1, ST_NO_MOV, 2'd0, 32'd0, 32'd0, 1'b0);
        check("hold_elem0", 64'(st_write_elem0), 64'd2);
        run_cmd("swp", CMD_SWP, 10'd2, 32'd2, 32'd1, 1'b0, 1, 4, ST_NO_MOV, 2'd2, 32'd2, 32'd1, 1'b0);
        run_cmd("dup_full", CMD_DUP, 10'd512, 32'd0, 32'd9, 1'b1, -1, 1, ST_NO_MOV, 2'd0, 32'd0, 32'd0, 1'b0);
        run_cmd("add_under", CMD_ADD, 10'd1, 32'd1, 32'd1, 1'b1, -1, 1, ST_NO_MOV, 2'd0, 32'd0, 32'd0, 1'b0);
        run_cmd("pop_empty", CMD_POP, 10'd0, 32'd0, 32'd0, 1'b1, -1, 1, ST_NO_MOV, 2'd0, 32'd0, 32'd0, 1'b0);
        run_cmd("pop_extra", CMD_POP, 10'd3, 32'd4, 32'd6, 1'b0, 1, 4, ST_MOV_DN, 2'd0, 32'd0, 32'd0, 1'b1);
        run_cmd("dup", CMD_DUP, 10'd5, 32'd1, 32'hABCD, 1'b0, 1, 4, ST_MOV_UP, 2'd1, 32'hABCD, 32'd0, 1'b0);

        // Reset in cycle 10 of a divide: outputs clear at once and nothing is issued.
        cmd = CMD_DIV; elems_cnt = 10'd2; top1 = 32'd100; top0 = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset_n = 1'b0;
        #1;
        check("mid_reset_ctrl", {60'd0, busy, done, err, st_en}, 64'd0);
        check("mid_reset_fields", {60'd0, st_write_elems_cnt, st_top_mov}, 64'd0);
        check("mid_reset_elem0", 64'(st_write_elem0), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || st_en || busy) stray++;
            tick();
        end
        check("mid_reset_quiet", 64'(stray), 64'd0);
        $display("[TB] reset during divide: stray activity cycles=%0d", stray);
        run_cmd("add_after_rst", CMD_ADD, 10'd2, 32'd20, 32'd22, 1'b0, 1, 4, ST_MOV_DN, 2'd1, 32'd42, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
